// File: rtl/move_pkg.sv
// Shared definitions for the move input path: direction codes, controller
// FSM encoding and the press-priority helper.
package move_pkg;

    // Direction codes, also used by the game controller
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Request FSM: wait for a press, hold the request, wait for full release
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        LOCK = 2'd2
    } move_state_t;

    // Press vector is {left,down,right,up}; lowest index wins (up > right > down > left)
    function automatic logic [1:0] prio_dir(input logic [3:0] press);
        logic [1:0] d;
        if (press[0]) begin
            d = DIR_UP;
        end else if (press[1]) begin
            d = DIR_RIGHT;
        end else if (press[2]) begin
            d = DIR_DOWN;
        end else begin
            d = DIR_LEFT;
        end
        return d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, debounced level
// and a registered single-cycle press pulse on each debounced 0->1 edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    // Counter value at which a still-differing input is accepted as the new level
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             synced;

    assign synced = sync_q[1];

    // Bring the raw asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Count consecutive cycles of disagreement; flip the level once it has lasted long enough
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == LAST_CNT) begin
                level_d = synced;
                cnt_d   = '0;
                // Pulse is registered together with the level flip so it appears in the same cycle
                press_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/move_input_ctrl.sv
// Turns four raw direction buttons into one move request per physical press,
// presented on a valid/ready handshake, and counts accepted moves.
module move_input_ctrl
    import move_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int MOVE_CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_up,
    input  logic                  btn_right,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  move_ready,
    output logic                  move_valid,
    output logic [1:0]            dir,
    output logic [MOVE_CNT_W-1:0] move_count,
    output logic [3:0]            btn_state
);

    logic [3:0] btn_raw;
    logic [3:0] level;
    logic [3:0] press;

    move_state_t           state_q;
    move_state_t           state_d;
    logic                  valid_q;
    logic                  valid_d;
    logic [1:0]            dir_q;
    logic [1:0]            dir_d;
    logic [MOVE_CNT_W-1:0] count_q;
    logic [MOVE_CNT_W-1:0] count_d;

    // Bit index matches the direction code: 0=up, 1=right, 2=down, 3=left
    assign btn_raw = {btn_left, btn_down, btn_right, btn_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk     (clk),
                .rst_n   (rst),
                .btn_i   (btn_raw[gi]),
                .level_o (level[gi]),
                .press_o (press[gi])
            );
        end
    endgenerate

    // Next-state and output logic for the request FSM and the move counter
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dir_d   = dir_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (|press) begin
                    dir_d   = prio_dir(press);
                    valid_d = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                // Only a registered-high valid can complete a handshake
                if (valid_q && move_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + MOVE_CNT_W'(1);
                    state_d = LOCK;
                end
            end
            LOCK: begin
                // No new request until every button is debounced released
                if (level == 4'b0000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM, request and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dir_q   <= DIR_UP;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            count_q <= count_d;
        end
    end

    assign move_valid = valid_q;
    assign dir        = dir_q;
    assign move_count = count_q;
    assign btn_state  = level;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboard bench for move_input_ctrl with a short debounce window.
module tb_move_input_ctrl;
    import move_pkg::*;

    localparam int DEB = 4;
    localparam int CW  = 3;
    localparam int MW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_up = 1'b0;
    logic          btn_right = 1'b0;
    logic          btn_down = 1'b0;
    logic          btn_left = 1'b0;
    logic          move_ready = 1'b0;
    logic          move_valid;
    logic [1:0]    dir;
    logic [MW-1:0] move_count;
    logic [3:0]    btn_state;

    int tests = 0;
    int fails = 0;

    logic [1:0]    exp_dir_q[$];
    logic [MW-1:0] exp_cnt_q[$];
    logic [MW-1:0] exp_count = '0;
    logic          prev_valid = 1'b0;
    logic [1:0]    held_dir = 2'd0;

    move_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW),
        .MOVE_CNT_W      (MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .dir        (dir),
        .move_count (move_count),
        .btn_state  (btn_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end else begin
            $display("[TB] ok   %s = %0h", name, actual);
        end
    endtask

    // Monitor: every handshake pops the scoreboard; unexpected requests are flagged
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (move_valid && !prev_valid)
                check("request_expected", 32'(exp_dir_q.size() != 0), 32'd1);
            if (move_valid && prev_valid)
                check("dir_stable", 32'(dir), 32'(held_dir));
            if (move_valid && move_ready && exp_dir_q.size() != 0) begin
                check("hs_dir", 32'(dir), 32'(exp_dir_q.pop_front()));
                check("hs_count", 32'(move_count), 32'(exp_cnt_q.pop_front()));
            end
            prev_valid <= move_valid;
            held_dir   <= dir;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_move(input logic [1:0] d);
        exp_dir_q.push_back(d);
        exp_cnt_q.push_back(exp_count);
        exp_count = exp_count + MW'(1);
    endtask

    task automatic set_btn(input logic [1:0] idx, input logic val);
        case (idx)
            2'd0: btn_up    = val;
            2'd1: btn_right = val;
            2'd2: btn_down  = val;
            default: btn_left = val;
        endcase
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        while (!move_valid && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(move_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_dir_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(exp_dir_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int bad;
        int saw;

        // Reset values
        tick(2);
        check("rst_valid", 32'(move_valid), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_count", 32'(move_count), 32'd0);
        check("rst_btn_state", 32'(btn_state), 32'd0);
        rst = 1'b1;
        tick(3);

        // Clean press: 7-cycle latency, one-cycle request, no auto-repeat
        move_ready = 1'b1;
        expect_move(DIR_RIGHT);
        btn_right = 1'b1;
        lat = 0;
        while (!move_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("clean_latency", 32'(lat), 32'd7);
        tick();
        check("clean_valid_one_cycle", 32'(move_valid), 32'd0);
        check("clean_count", 32'(move_count), 32'd1);
        tick(12);
        btn_right = 1'b0;
        tick(15);

        // Bounce rejection: runs of 2 cycles never reach the debounce window
        bad = 0;
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) btn_up = ~btn_up;
            tick();
            if (btn_state != 4'b0000) bad++;
            if (move_valid) saw++;
        end
        btn_up = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (btn_state != 4'b0000) bad++;
            if (move_valid) saw++;
        end
        check("bounce_btn_state_zero", 32'(bad), 32'd0);
        check("bounce_no_valid", 32'(saw), 32'd0);

        // Back-pressure: request held for 30 stalled cycles
        move_ready = 1'b0;
        expect_move(DIR_DOWN);
        btn_down = 1'b1;
        wait_valid("bp_valid_rises", 20);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!(move_valid && dir == DIR_DOWN)) bad++;
        end
        check("bp_held_during_stall", 32'(bad), 32'd0);
        move_ready = 1'b1;
        wait_drain("bp_drain", 5);
        tick();
        check("bp_count", 32'(move_count), 32'(exp_count));
        btn_down = 1'b0;
        tick(15);

        // Simultaneous left+up: up wins; a later left alone gives left
        expect_move(DIR_UP);
        btn_left = 1'b1;
        btn_up   = 1'b1;
        tick(12);
        wait_drain("sim_first", 10);
        btn_left = 1'b0;
        btn_up   = 1'b0;
        tick(15);
        expect_move(DIR_LEFT);
        btn_left = 1'b1;
        tick(12);
        wait_drain("sim_second", 10);
        btn_left = 1'b0;
        tick(15);
        check("sim_count", 32'(move_count), 32'(exp_count));

        // Press during PEND/LOCK is ignored
        move_ready = 1'b0;
        expect_move(DIR_DOWN);
        btn_down = 1'b1;
        wait_valid("pend_valid_rises", 20);
        btn_right = 1'b1;
        tick(10);
        check("pend_btn_state", 32'(btn_state), 32'h6);
        btn_down  = 1'b0;
        btn_right = 1'b0;
        tick(20);
        move_ready = 1'b1;
        wait_drain("pend_drain", 5);
        tick(20);
        check("pend_count", 32'(move_count), 32'(exp_count));

        // Reset mid-PEND drops the request and clears the counter
        move_ready = 1'b0;
        expect_move(DIR_UP);
        btn_up = 1'b1;
        wait_valid("rstp_valid_rises", 20);
        tick(2);
        btn_up = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("rstp_valid_async", 32'(move_valid), 32'd0);
        check("rstp_count_async", 32'(move_count), 32'd0);
        check("rstp_btn_state", 32'(btn_state), 32'd0);
        tick();
        exp_dir_q.delete();
        exp_cnt_q.delete();
        exp_count = '0;
        rst = 1'b1;
        move_ready = 1'b1;
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (move_valid) saw++;
        end
        check("rstp_no_valid_after", 32'(saw), 32'd0);
        expect_move(DIR_RIGHT);
        btn_right = 1'b1;
        tick(12);
        wait_drain("rstp_idle_accepts", 10);
        btn_right = 1'b0;
        tick(15);
        check("rstp_count_after", 32'(move_count), 32'd1);

        // Counter wrap: 15 more moves take the 4-bit count from 1 through 15 to 0
        for (int i = 0; i < 15; i++) begin
            expect_move(2'(i % 4));
            set_btn(2'(i % 4), 1'b1);
            tick(10);
            wait_drain("wrap_drain", 10);
            set_btn(2'(i % 4), 1'b0);
            tick(12);
        end
        check("wrap_count", 32'(move_count), 32'd0);
        check("scoreboard_empty", 32'(exp_dir_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
